if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the RV32I pipeline: owns the PC, issues word fetches to instruction
//  memory over a valid/ready request + valid response interface, and fills the IF/ID register
//  whose ifid_instr feeds decode and immediate generation. Honours decode stalls and EX redirects.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  NOP_INSTR 32'h0000_0013  ifid_instr value when bubble (addi x0,x0,0)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   reset, synchronous, active-high
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  fetch address (word aligned)
//  imem_rsp_valid  in   1   response data valid (one per accepted request, >=1 cycle later)
//  imem_rsp_data   in   32  fetched instruction word
//  id_stall        in   1   hazard unit: hold IF/ID contents
//  redirect_valid  in   1   EX branch/jump taken or flush
//  redirect_pc     in   32  redirect target
//  ifid_valid      out  1   IF/ID holds a live instruction
//  ifid_instr      out  32  instruction to decode
//  ifid_pc         out  32  PC of ifid_instr
//  ifid_pc_plus4   out  32  ifid_pc + 4 (mod 2^32)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=REQ, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=0,
//    kill=0, hold buffer empty; imem_req_valid=0 while rst=1.
//  - Single outstanding request. FSM states:
//    REQ : imem_req_valid=1, imem_req_addr=pc. On req_valid&req_ready -> WAIT, latch req_pc=pc.
//    WAIT: on rsp_valid: if kill -> drop word, kill=0, REQ. Else if slot free (!ifid_valid | !id_stall)
//          -> load IF/ID {1,data,req_pc,req_pc+4}, pc=req_pc+4, REQ. Else -> store in hold buffer, HOLD.
//    HOLD: when !id_stall -> move hold buffer to IF/ID, pc=req_pc+4, REQ.
//  - Slot free with no new word: if !id_stall, ifid_valid<=0 and ifid_instr<=NOP_INSTR (bubble).
//  - id_stall=1: IF/ID registers unchanged; fetch may still complete into hold buffer.
//  - Redirect (priority over stall and response): pc<=redirect_pc; ifid_valid<=0, ifid_instr<=NOP_INSTR;
//    REQ -> REQ (same-cycle accepted handshake still marks kill=1 and goes WAIT); WAIT -> set kill=1
//    (response for that request arriving the same cycle is dropped, kill stays 0, -> REQ);
//    HOLD -> discard buffer, REQ. Redirect while kill already 1: keep kill, update pc.
//  - PC arithmetic 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000.
//  - Latency: request accepted cycle t, response cycle t+k, ifid_valid visible cycle t+k+1.
//  - Throughput with 1-cycle memory: one instruction per 2 cycles (REQ, WAIT alternate).
//  - imem_req_valid, once high in REQ, stays high with stable addr until ready, unless redirect
//    changes pc (then addr follows new pc next cycle).
// CONFIGURATION
//  IF_MISALIGN_TRAP_EN defined: extra output ifid_misalign (1 bit). redirect_pc[1:0]!=0 is still
//    loaded; no memory request issued; IF/ID loaded with {valid=1, NOP_INSTR, pc, pc+4,
//    ifid_misalign=1}; FSM stays idle until next redirect or reset. ifid_misalign reset to 0.
//  Not defined: no ifid_misalign port; redirect_pc[1:0] forced to 2'b00 before loading pc.
// TESTING
//  1. Reset, ready=1, 1-cycle memory returning 0x00500093 at 0x0 -> ifid_valid=1, ifid_pc=0x0,
//     ifid_pc_plus4=0x4, ifid_instr=0x00500093; next req addr 0x4.
//  2. id_stall=1 for 5 cycles with response arriving -> IF/ID unchanged, word held; stall drop ->
//     held word appears next cycle, no request for it reissued.
//  3. redirect_valid=1, redirect_pc=0x100 during WAIT -> stale response dropped, ifid_valid=0,
//     next req addr 0x100, ifid_pc=0x100 on following fill.
//  4. imem_req_ready=0 for 3 cycles -> req_valid held high, addr stable; no IF/ID change.
//  5. pc=0xFFFF_FFFC fetch -> ifid_pc_plus4=0x0, next req addr 0x0.
//  6. rst asserted in WAIT/HOLD -> next cycle pc=RESET_PC, ifid_valid=0, ifid_instr=0x00000013,
//     late response ignored; with IF_MISALIGN_TRAP_EN, redirect 0x102 -> ifid_misalign=1, no request.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Bundle between the fetch stage, instruction memory, the hazard unit, EX redirect and decode.
// IF_MISALIGN_TRAP_EN adds the ifid_misalign flag.
interface if_fetch_stage_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_plus4;
`ifdef IF_MISALIGN_TRAP_EN
   logic        ifid_misalign;
`endif

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  id_stall, redirect_valid, redirect_pc,
`ifdef IF_MISALIGN_TRAP_EN
      output ifid_misalign,
`endif
      output ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output id_stall, redirect_valid, redirect_pc,
`ifdef IF_MISALIGN_TRAP_EN
      input  ifid_misalign,
`endif
      input  ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4
   );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem fetch, IF/ID register with hold buffer.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect loads a trap bubble and idles the fetcher.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input logic             clk,
   input logic             rst,
   if_fetch_stage_if.master bus
);
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_IDLE} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_req_pc;
   logic [31:0] r_hold_data;
   logic        r_kill;
   logic        r_ifid_valid;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc;
   logic [31:0] r_ifid_pc_plus4;

   logic        w_req_fire;
   logic        w_slot_free;
   logic [31:0] w_req_pc_plus4;
   logic [31:0] w_redirect_pc;

   assign w_req_fire     = (r_state == S_REQ) & bus.imem_req_ready;
   assign w_slot_free    = ~r_ifid_valid | ~bus.id_stall;
   assign w_req_pc_plus4 = r_req_pc + 32'd4;

`ifdef IF_MISALIGN_TRAP_EN
   logic r_ifid_misalign;
   logic w_misalign;
   assign w_redirect_pc     = bus.redirect_pc;
   assign w_misalign        = |bus.redirect_pc[1:0];
   assign bus.ifid_misalign = r_ifid_misalign;
`else
   assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};
`endif

   assign bus.imem_req_valid = (r_state == S_REQ) & ~rst;
   assign bus.imem_req_addr  = r_pc;
   assign bus.ifid_valid     = r_ifid_valid;
   assign bus.ifid_instr     = r_ifid_instr;
   assign bus.ifid_pc        = r_ifid_pc;
   assign bus.ifid_pc_plus4  = r_ifid_pc_plus4;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_REQ;
         r_pc            <= RESET_PC;
         r_req_pc        <= RESET_PC;
         r_hold_data     <= NOP_INSTR;
         r_kill          <= 1'b0;
         r_ifid_valid    <= 1'b0;
         r_ifid_instr    <= NOP_INSTR;
         r_ifid_pc       <= 32'd0;
         r_ifid_pc_plus4 <= 32'd0;
`ifdef IF_MISALIGN_TRAP_EN
         r_ifid_misalign <= 1'b0;
`endif
      end else if (bus.redirect_valid) begin
         r_pc         <= w_redirect_pc;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= NOP_INSTR;
`ifdef IF_MISALIGN_TRAP_EN
         r_ifid_misalign <= 1'b0;
`endif
         // A request still in flight must have its response swallowed via r_kill.
         case (r_state)
            S_REQ: begin
               if (w_req_fire) begin
                  r_kill  <= 1'b1;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.imem_rsp_valid) begin
                  r_kill  <= 1'b0;
                  r_state <= S_REQ;
               end else begin
                  r_kill <= 1'b1;
               end
            end
            S_HOLD: r_state <= S_REQ;
            S_IDLE: begin
               if (bus.imem_rsp_valid) r_kill <= 1'b0;
               r_state <= S_REQ;
            end
            default: r_state <= S_REQ;
         endcase
`ifdef IF_MISALIGN_TRAP_EN
         if (w_misalign) begin
            r_state         <= S_IDLE;
            r_ifid_valid    <= 1'b1;
            r_ifid_pc       <= w_redirect_pc;
            r_ifid_pc_plus4 <= w_redirect_pc + 32'd4;
            r_ifid_misalign <= 1'b1;
         end
`endif
      end else begin
         // Bubble by default when decode is consuming; a real load below overrides it.
         if (!bus.id_stall) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
`ifdef IF_MISALIGN_TRAP_EN
            r_ifid_misalign <= 1'b0;
`endif
         end
         case (r_state)
            S_REQ: begin
               if (bus.imem_rsp_valid && r_kill) r_kill <= 1'b0;
               if (w_req_fire) begin
                  r_req_pc <= r_pc;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.imem_rsp_valid) begin
                  if (r_kill) begin
                     r_kill  <= 1'b0;
                     r_state <= S_REQ;
                  end else if (w_slot_free) begin
                     r_ifid_valid    <= 1'b1;
                     r_ifid_instr    <= bus.imem_rsp_data;
                     r_ifid_pc       <= r_req_pc;
                     r_ifid_pc_plus4 <= w_req_pc_plus4;
                     r_pc            <= w_req_pc_plus4;
                     r_state         <= S_REQ;
                  end else begin
                     r_hold_data <= bus.imem_rsp_data;
                     r_state     <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!bus.id_stall) begin
                  r_ifid_valid    <= 1'b1;
                  r_ifid_instr    <= r_hold_data;
                  r_ifid_pc       <= r_req_pc;
                  r_ifid_pc_plus4 <= w_req_pc_plus4;
                  r_pc            <= w_req_pc_plus4;
                  r_state         <= S_REQ;
               end
            end
            S_IDLE: begin
               if (bus.imem_rsp_valid && r_kill) r_kill <= 1'b0;
            end
            default: r_state <= S_REQ;
         endcase
      end
   end
endmodule
